paint_fb_writer: RTL and testbench
==================================

# paint_fb_writer

Framebuffer write engine for the 64x64, 12 bpp paint panel. Accepts plot and clear commands (from the mouse/cursor logic) and performs read-modify-write accesses on the write port of the dual-port framebuffer. The LED panel driver scans that framebuffer on its read port. Each framebuffer word packs the two pixels that the panel shifts out together: the top-half row and the bottom-half row.

## Interface
Parameters:
- BG_COLOR, 12'h000: RGB444 value written by a clear.
- ADDR_W, 11: framebuffer word address width, 2048 words.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_op  in  1  0 = plot, 1 = clear screen
- cmd_x  in  6  column 0..63
- cmd_y  in  6  row 0..63
- cmd_color  in  12  {R[3:0],G[3:0],B[3:0]}
- cmd_brush  in  1  0 = 1x1, 1 = 3x3; only present with PAINT_BRUSH3_EN
- busy  out  1  ~cmd_ready
- mem_addr  out  ADDR_W  word address {y[4:0], x[5:0]}
- mem_rd  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  24  {top_pixel[23:12], bottom_pixel[11:0]}
- mem_wr  out  1  write strobe
- mem_wdata  out  24  write data

## Operation
- Pixel mapping:
  - Word address = {y[4:0], x}.
  - y[5]=0 selects the top pixel, bits [23:12].
  - y[5]=1 selects the bottom pixel, bits [11:0].
- All command fields are registered on acceptance. Later input changes are ignored until cmd_ready returns high.
- FSM states: IDLE, CLEAR, NEXT, RD, WR.
- IDLE:
  - cmd_ready=1.
  - On accept: op=1 goes to CLEAR; op=0 goes to NEXT with offset (dx,dy) = (-1,-1) for a 3x3 brush, else (0,0).
- CLEAR:
  - mem_wr=1 and mem_wdata={BG_COLOR,BG_COLOR} every cycle.
  - mem_addr sweeps 0..2047, one per cycle.
  - Returns to IDLE after address 2047.
- NEXT:
  - Computes px=x+dx and py=y+dy as 7-bit signed values.
  - If 0<=px<=63 and 0<=py<=63, goes to RD.
  - Otherwise the offset is clipped: no memory access, advance the offset, and stay in NEXT. After the last offset, go to IDLE.
  - Coordinates never wrap.
- RD: mem_rd=1 with the target address, then goes to WR.
- WR:
  - mem_wr=1 at the same address.
  - mem_wdata = mem_rdata with only the selected 12-bit half replaced by color; the other half passes through unchanged.
  - Advances the offset, then goes to NEXT, or to IDLE after the last offset.
- Offset order is raster: dy=-1..1 outer, dx=-1..1 inner. A 1x1 brush has the single offset (0,0).
- mem_rd and mem_wr are never asserted in the same cycle.
- Outside RD/WR/CLEAR, mem_rd=mem_wr=0; mem_addr and mem_wdata are don't-care.

## Timing
- Reset values:
  - cmd_ready=1, busy=0.
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - State IDLE.
- rst mid-operation aborts at the next edge. Already-written words remain; there is no rollback.
- All outputs are registered except cmd_ready and busy, which decode the state.
- mem_wdata in WR is combinational from mem_rdata. This relies on the framebuffer's 1-cycle synchronous read.
- Latency, counted as cycles from the accept edge until cmd_ready is high again:
  - 1x1 in range: 3 (NEXT, RD, WR).
  - 3x3 fully in range: 27 (9 x NEXT/RD/WR).
  - 3x3 at a corner: 4 in range x 3 + 5 clipped x 1 = 17.
  - Clear: 2048.
- A back-to-back command may be accepted in the cycle cmd_ready returns high.

## Configuration
- PAINT_BRUSH3_EN defined:
  - The cmd_brush port exists.
  - The 3x3 offset iterator and clipping are built.
- PAINT_BRUSH3_EN undefined:
  - No cmd_brush port; every plot is 1x1.
  - The NEXT clip check is reduced to the single (0,0) offset, which is always in range.

## Test plan
- Reset, then clear with BG_COLOR=12'h000 -> 2048 consecutive writes, addresses 0..2047, wdata 24'h000000, cmd_ready high again after 2048 cycles.
- Preload word 11'h7FF=24'hABC123; plot (x=63, y=63, color 12'hF00, 1x1) -> rd at 11'h7FF, then wr 24'hABCF00, with the top half preserved.
- Plot (x=5, y=2, color 12'h0F0), word preloaded 24'h111222 -> wr at {5'd2,6'd5}=11'h085 with 24'h0F0222.
- 3x3 plot at (0,0), PAINT_BRUSH3_EN -> exactly 4 writes, at addresses 0, 1, 64, 65 in that order, and 17 busy cycles.
- 3x3 plot at (10,31) -> rows 30 and 31 write the top half (words 30·64+9..11 and 31·64+9..11). Row 32 writes the bottom half at words 9..11. 27 busy cycles.
- Assert rst during the 100th cycle of a clear -> next cycle mem_wr=0 and cmd_ready=1; a subsequent plot executes normally.

Source files
------------

// File: rtl/paint_fb_writer.sv
// paint_fb_writer: framebuffer write engine for the 64x64, 12 bpp paint panel.
// It takes plot and clear commands and issues read-modify-write cycles on the
// write port of the dual-port framebuffer. Each 24-bit word holds the top-half
// pixel in [23:12] and the matching bottom-half pixel in [11:0].
// Build option: define PAINT_BRUSH3_EN to add the cmd_brush port and the 3x3
// brush with edge clipping. Without it, every plot is a single pixel.
module paint_fb_writer #(
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [5:0]        cmd_x,
    input  logic [5:0]        cmd_y,
    input  logic [11:0]       cmd_color,
`ifdef PAINT_BRUSH3_EN
    input  logic              cmd_brush,
`endif
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [23:0]       mem_rdata,
    output logic              mem_wr,
    output logic [23:0]       mem_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        NEXT,
        RD,
        WR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t      state;
    logic [5:0]  x_q;
    logic [5:0]  y_q;
    logic [11:0] color_q;
    logic        bottom_q;   // target pixel lives in the low half of the word
    logic [23:0] wdata_q;    // registered write data, used while clearing

    logic [6:0]  tgt_x;
    logic [6:0]  tgt_y;
    logic        in_range;
    logic        last_off;

`ifdef PAINT_BRUSH3_EN
    logic        brush_q;
    logic [1:0]  dx_q;       // two's complement offset: -1, 0 or +1
    logic [1:0]  dy_q;
    logic [1:0]  dx_nxt;
    logic [1:0]  dy_nxt;

    // Current brush target, clip test and the next raster-order offset.
    always_comb begin
        // NOTE: every output of a combinational block gets a value up front so
        // no path can leave it unassigned and infer a latch.
        tgt_x    = {1'b0, x_q} + {{5{dx_q[1]}}, dx_q};
        tgt_y    = {1'b0, y_q} + {{5{dy_q[1]}}, dy_q};
        dx_nxt   = dx_q + 2'b01;
        dy_nxt   = dy_q;
        // Offsets are at most +-1, so the only out-of-range results are -1 and 64,
        // and both have bit 6 set.
        in_range = ~tgt_x[6] & ~tgt_y[6];
        last_off = ~brush_q | ((dx_q == 2'b01) && (dy_q == 2'b01));
        if (dx_q == 2'b01) begin
            dx_nxt = 2'b11;
            dy_nxt = dy_q + 2'b01;
        end
    end
`else
    // A single-pixel plot always targets the commanded pixel, which is always on screen.
    always_comb begin
        tgt_x    = {1'b0, x_q};
        tgt_y    = {1'b0, y_q};
        in_range = 1'b1;
        last_off = 1'b1;
    end
`endif

    // Handshake status is decoded directly from the state.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = ~cmd_ready;
    end

    // Merge the new color into the word read back in RD. The other half passes through.
    always_comb begin
        mem_wdata = wdata_q;
        if (state == WR) begin
            mem_wdata = bottom_q ? {mem_rdata[23:12], color_q}
                                 : {color_q, mem_rdata[11:0]};
        end
    end

    // Command sequencer: one always_ff updates the state and the registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all state is updated with non-blocking assignments, so each
            // branch sees the pre-edge values regardless of statement order.
            state    <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            bottom_q <= 1'b0;
            wdata_q  <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
`ifdef PAINT_BRUSH3_EN
            brush_q  <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        color_q <= cmd_color;
                        if (cmd_op) begin
                            state    <= CLEAR;
                            mem_wr   <= 1'b1;
                            mem_addr <= '0;
                            wdata_q  <= {BG_COLOR, BG_COLOR};
                        end else begin
                            state <= NEXT;
`ifdef PAINT_BRUSH3_EN
                            brush_q <= cmd_brush;
                            dx_q    <= cmd_brush ? 2'b11 : 2'b00;
                            dy_q    <= cmd_brush ? 2'b11 : 2'b00;
`endif
                        end
                    end
                end
                CLEAR: begin
                    if (mem_addr == LAST_ADDR) begin
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                NEXT: begin
                    if (in_range) begin
                        state    <= RD;
                        mem_rd   <= 1'b1;
                        mem_addr <= ADDR_W'({tgt_y[4:0], tgt_x[5:0]});
                        bottom_q <= tgt_y[5];
                    end else begin
                        // A clipped offset costs one cycle and touches no memory.
                        if (last_off) state <= IDLE;
`ifdef PAINT_BRUSH3_EN
                        dx_q <= dx_nxt;
                        dy_q <= dy_nxt;
`endif
                    end
                end
                RD: begin
                    state  <= WR;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b1;
                end
                WR: begin
                    mem_wr <= 1'b0;
                    state  <= last_off ? IDLE : NEXT;
`ifdef PAINT_BRUSH3_EN
                    dx_q <= dx_nxt;
                    dy_q <= dy_nxt;
`endif
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_fb_writer.sv
// tb_paint_fb_writer: directed bench for paint_fb_writer. A behavioural
// framebuffer with a one-cycle synchronous read answers the engine, and every
// read and write is logged so expected addresses and data can be compared.
// The 3x3 brush vectors are included when PAINT_BRUSH3_EN is defined.
module tb_paint_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [11:0] cmd_color;
`ifdef PAINT_BRUSH3_EN
    logic        cmd_brush;
`endif
    logic        busy;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic [23:0] mem_rdata;
    logic        mem_wr;
    logic [23:0] mem_wdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    paint_fb_writer #(.BG_COLOR(12'h000), .ADDR_W(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_color (cmd_color),
`ifdef PAINT_BRUSH3_EN
        .cmd_brush (cmd_brush),
`endif
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    // Framebuffer model with a preload port and access logs.
    logic [23:0] fb [0:2047];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [23:0] pl_data = '0;
    logic [10:0] wr_addr_log [0:4095];
    logic [23:0] wr_data_log [0:4095];
    logic [10:0] rd_addr_log [0:4095];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) fb[pl_addr] <= pl_data;
        if (mem_rd) begin
            mem_rdata                 <= fb[mem_addr];
            rd_addr_log[rd_cnt & 4095] <= mem_addr;
            rd_cnt                    <= rd_cnt + 1;
        end
        if (mem_wr) begin
            fb[mem_addr]              <= mem_wdata;
            wr_addr_log[wr_cnt & 4095] <= mem_addr;
            wr_data_log[wr_cnt & 4095] <= mem_wdata;
            wr_cnt                    <= wr_cnt + 1;
        end
        if (mem_rd && mem_wr) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [10:0] a, input logic [23:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Present one command and return right after the accept edge; the fields
    // are then scrambled to show the engine works from its own copies.
    task automatic start_cmd(input logic op, input logic [5:0] x, input logic [5:0] y,
                             input logic [11:0] color, input logic brush);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_color = color;
`ifdef PAINT_BRUSH3_EN
        cmd_brush = brush;
`else
        if (brush) $display("note: brush request ignored in this build");
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_x     = ~x;
        cmd_y     = ~y;
        cmd_color = ~color;
`ifdef PAINT_BRUSH3_EN
        cmd_brush = ~brush;
`endif
    endtask

    // Busy cycles after the accept edge, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!cmd_ready && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_cmd(input logic op, input logic [5:0] x, input logic [5:0] y,
                           input logic [11:0] color, input logic brush, output int cycles);
        start_cmd(op, x, y, color, brush);
        wait_idle(cycles);
    endtask

    initial begin
        int cyc;
        int wbase;
        int rbase;
        int errs;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_color = '0;
`ifdef PAINT_BRUSH3_EN
        cmd_brush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_mem_rd",    32'(mem_rd),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Full clear: 2048 writes of zero at ascending addresses
        wbase = wr_cnt;
        run_cmd(1'b1, 6'd0, 6'd0, 12'h000, 1'b0, cyc);
        check("clear_latency", 32'(cyc), 32'd2048);
        check("clear_writes",  32'(wr_cnt - wbase), 32'd2048);
        errs = 0;
        for (int i = 0; i < 2048; i++) begin
            if (wr_addr_log[(wbase + i) & 4095] != 11'(i)) errs++;
            if (wr_data_log[(wbase + i) & 4095] != 24'h000000) errs++;
        end
        check("clear_sequence_errs", 32'(errs), 32'd0);

        // Bottom-half plot at the last word, top half preserved
        preload(11'h7FF, 24'hABC123);
        wbase = wr_cnt;
        rbase = rd_cnt;
        run_cmd(1'b0, 6'd63, 6'd63, 12'hF00, 1'b0, cyc);
        check("p63_latency", 32'(cyc), 32'd3);
        check("p63_reads",   32'(rd_cnt - rbase), 32'd1);
        check("p63_rd_addr", 32'(rd_addr_log[rbase & 4095]), 32'h7FF);
        check("p63_writes",  32'(wr_cnt - wbase), 32'd1);
        check("p63_wr_addr", 32'(wr_addr_log[wbase & 4095]), 32'h7FF);
        check("p63_wr_data", 32'(wr_data_log[wbase & 4095]), 32'hABCF00);

        // Top-half plot, bottom half preserved
        preload(11'h085, 24'h111222);
        wbase = wr_cnt;
        run_cmd(1'b0, 6'd5, 6'd2, 12'h0F0, 1'b0, cyc);
        check("p52_latency", 32'(cyc), 32'd3);
        check("p52_wr_addr", 32'(wr_addr_log[wbase & 4095]), 32'h085);
        check("p52_wr_data", 32'(wr_data_log[wbase & 4095]), 32'h0F0222);

`ifdef PAINT_BRUSH3_EN
        // 3x3 at the top-left corner: five offsets clipped, four written
        begin
            logic [10:0] exp_c [0:3];
            exp_c[0] = 11'd0; exp_c[1] = 11'd1; exp_c[2] = 11'd64; exp_c[3] = 11'd65;
            wbase = wr_cnt;
            run_cmd(1'b0, 6'd0, 6'd0, 12'h00F, 1'b1, cyc);
            check("b00_latency", 32'(cyc), 32'd17);
            check("b00_writes",  32'(wr_cnt - wbase), 32'd4);
            for (int i = 0; i < 4; i++)
                check($sformatf("b00_addr%0d", i), 32'(wr_addr_log[(wbase + i) & 4095]), 32'(exp_c[i]));
        end

        // 3x3 straddling the top/bottom row boundary at y=31/32
        begin
            logic [10:0] exp_a [0:8];
            logic [23:0] exp_d [0:8];
            for (int i = 0; i < 3; i++) begin
                exp_a[i]     = 11'(30 * 64 + 9 + i);
                exp_a[3 + i] = 11'(31 * 64 + 9 + i);
                exp_a[6 + i] = 11'(9 + i);
                exp_d[i]     = 24'h3C7AAA;
                exp_d[3 + i] = 24'h3C7AAA;
                exp_d[6 + i] = 24'h5553C7;
            end
            for (int i = 0; i < 9; i++) preload(exp_a[i], 24'h555AAA);
            wbase = wr_cnt;
            run_cmd(1'b0, 6'd10, 6'd31, 12'h3C7, 1'b1, cyc);
            check("b1031_latency", 32'(cyc), 32'd27);
            check("b1031_writes",  32'(wr_cnt - wbase), 32'd9);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("b1031_addr%0d", i), 32'(wr_addr_log[(wbase + i) & 4095]), 32'(exp_a[i]));
                check($sformatf("b1031_data%0d", i), 32'(wr_data_log[(wbase + i) & 4095]), 32'(exp_d[i]));
            end
        end
`endif

        // Reset during the 100th cycle of a clear
        wbase = wr_cnt;
        start_cmd(1'b1, 6'd0, 6'd0, 12'h000, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_wr",    32'(mem_wr),    32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_writes",    32'(wr_cnt - wbase), 32'd100);
        rst = 1'b0;

        // Normal plot after the abort, bottom half of row 40
        preload(11'h201, 24'h456789);
        wbase = wr_cnt;
        run_cmd(1'b0, 6'd1, 6'd40, 12'h123, 1'b0, cyc);
        check("post_latency", 32'(cyc), 32'd3);
        check("post_wr_addr", 32'(wr_addr_log[wbase & 4095]), 32'h201);
        check("post_wr_data", 32'(wr_data_log[wbase & 4095]), 32'h456123);

        check("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
